// File: rtl/axi_rx_pkg.sv
// Shared widths, checker history payload and LFSR helper for the 8-bit AXI-Stream receiver.
package axi_rx_pkg;

  localparam int unsigned AXIS_DATA_W = 8;
  localparam int unsigned STAT_W      = 16;
  localparam int unsigned LFSR_W      = 8;

  // Taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [AXIS_DATA_W-1:0] data;
  } axis_hist_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head is visible on dout_o whenever not empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push_c, do_pop_c;

  assign empty_o   = (level_q == LVL_W'(0));
  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign level_o   = level_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_push_c = push_i & ~full_o;
  assign do_pop_c  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push_c && !do_pop_c)      level_d = level_q + LVL_W'(1);
    else if (do_pop_c && !do_push_c) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates visibility of stale entries
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axi_8bit_receiver_sync.sv
// AXI-Stream byte sink: LFSR-throttled ready, FWFT buffer, statistics and input protocol checker.
module axi_8bit_receiver_sync
  import axi_rx_pkg::*;
#(
  parameter int unsigned        DEPTH         = 4,
  parameter bit                 THROTTLE_EN   = 1'b1,
  parameter logic [LFSR_W-1:0]  THROTTLE_MASK = 8'h03,
  parameter logic [LFSR_W-1:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axis_valid,
  input  logic [AXIS_DATA_W-1:0]  s_axis_data,
  output logic                    s_axis_ready,
  input  logic                    rd_en,
  output logic [AXIS_DATA_W-1:0]  rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [STAT_W-1:0]       byte_count,
  output logic [STAT_W-1:0]       checksum,
  output logic                    protocol_err
);

  localparam logic [LFSR_W-1:0] LFSR_RST = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [STAT_W-1:0] byte_count_q, byte_count_d;
  logic [STAT_W-1:0] checksum_q, checksum_d;
  logic              err_q, err_d;
  axis_hist_t        hist_q, hist_d;

  logic stall_c, full_c, empty_c, push_c, pop_c, viol_c;

  // Ready is a function of registered state and reset only, never of valid
  assign stall_c      = THROTTLE_EN & ((lfsr_q & THROTTLE_MASK) == 8'h00);
  assign s_axis_ready = rst_n & ~full_c & ~stall_c;
  assign push_c       = s_axis_valid & s_axis_ready;
  assign rd_valid     = ~empty_c;
  assign pop_c        = rd_en & rd_valid;

  assign byte_count   = byte_count_q;
  assign checksum     = checksum_q;
  assign protocol_err = err_q;

  sync_fifo_fwft #(
    .WIDTH (AXIS_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   (s_axis_data),
    .dout_o  (rd_data),
    .empty_o (empty_c),
    .full_o  (full_c),
    .level_o (fifo_level)
  );

  // A stalled beat must stay valid with stable data until accepted
  assign viol_c = hist_q.valid & ~hist_q.ready &
                  (~s_axis_valid | (s_axis_data != hist_q.data));

  always_comb begin
    lfsr_d       = lfsr_next(lfsr_q);
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    err_d        = err_q | viol_c;
    hist_d       = '{valid: s_axis_valid, ready: s_axis_ready, data: s_axis_data};
    if (push_c) begin
      byte_count_d = byte_count_q + STAT_W'(1);
      checksum_d   = checksum_q + STAT_W'(s_axis_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q       <= LFSR_RST;
      byte_count_q <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
      hist_q       <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
      hist_q       <= hist_d;
    end
  end

endmodule

// File: tb/tb_axi_8bit_receiver_sync.sv
// Directed bench: one unthrottled and one throttled instance sharing clock and reset.
module tb_axi_8bit_receiver_sync;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Unthrottled instance
  logic       nt_valid, nt_ready, nt_rd_en, nt_rvalid, nt_err;
  logic [7:0] nt_data, nt_rdata;
  logic [2:0] nt_level;
  logic [15:0] nt_cnt, nt_sum;

  // Throttled instance
  logic       th_valid, th_ready, th_rd_en, th_rvalid, th_err;
  logic [7:0] th_data, th_rdata;
  logic [2:0] th_level;
  logic [15:0] th_cnt, th_sum;

  axi_8bit_receiver_sync #(
    .DEPTH(4), .THROTTLE_EN(1'b0), .THROTTLE_MASK(8'h03), .LFSR_SEED(8'hA5)
  ) u_dut_nt (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(nt_valid), .s_axis_data(nt_data), .s_axis_ready(nt_ready),
    .rd_en(nt_rd_en), .rd_data(nt_rdata), .rd_valid(nt_rvalid),
    .fifo_level(nt_level), .byte_count(nt_cnt), .checksum(nt_sum),
    .protocol_err(nt_err)
  );

  axi_8bit_receiver_sync #(
    .DEPTH(4), .THROTTLE_EN(1'b1), .THROTTLE_MASK(8'h03), .LFSR_SEED(8'hA5)
  ) u_dut_th (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(th_valid), .s_axis_data(th_data), .s_axis_ready(th_ready),
    .rd_en(th_rd_en), .rd_data(th_rdata), .rd_valid(th_rvalid),
    .fifo_level(th_level), .byte_count(th_cnt), .checksum(th_sum),
    .protocol_err(th_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       rd_en;
    logic       exp_ready;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Settle point one time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_lfsr(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    nt_valid = 1'b0; nt_data = 8'h00; nt_rd_en = 1'b0;
    th_valid = 1'b0; th_data = 8'h00; th_rd_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic seek_stall(inout logic [7:0] l, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((l & 8'h03) == 8'h00) begin
        ok = 1'b1;
        break;
      end
      tick();
      l = ref_lfsr(l);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  lm;
    logic [7:0]  d;
    logic [15:0] acc, cs;
    bit          exp_rdy, ok;

    // in: valid data rd_en | exp: ready rvalid rdata level
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
    vecs[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h11, 3'd4};
    vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h22, 3'd3};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 3'd4};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd3};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};

    // Reset held with a beat offered
    rst_n = 1'b0;
    nt_valid = 1'b1; nt_data = 8'h3C; nt_rd_en = 1'b0;
    th_valid = 1'b1; th_data = 8'h3C; th_rd_en = 1'b0;
    tick(); tick(); tick();
    chk("rst_nt_ready", nt_ready, 0);
    chk("rst_th_ready", th_ready, 0);
    chk("rst_nt_rvalid", nt_rvalid, 0);
    chk("rst_th_rvalid", th_rvalid, 0);
    chk("rst_nt_level", nt_level, 0);
    chk("rst_nt_count", nt_cnt, 0);
    chk("rst_th_count", th_cnt, 0);
    chk("rst_nt_sum", nt_sum, 0);
    chk("rst_th_err", th_err, 0);
    nt_valid = 1'b0; th_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_nt_ready", nt_ready, 1);
    chk("rel_th_ready", th_ready, ((8'hA5 & 8'h03) != 0) ? 1 : 0);

    // Throttle pattern against the reference LFSR
    do_reset();
    lm = 8'hA5; d = 8'h00; acc = 16'h0; cs = 16'h0;
    th_rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_rdy = ((lm & 8'h03) != 8'h00);
      chk("thr_ready", th_ready, exp_rdy);
      th_valid = 1'b1; th_data = d;
      tick();
      if (exp_rdy) begin
        acc = acc + 16'd1;
        cs  = cs + 16'(d);
        d   = d + 8'd1;
      end
      lm = ref_lfsr(lm);
    end
    th_valid = 1'b0;
    chk("thr_count", th_cnt, acc);
    chk("thr_sum", th_sum, cs);
    chk("thr_err", th_err, 0);

    // Full-rate stream 00..FF with continuous reads
    do_reset();
    nt_rd_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("strm_ready", nt_ready, 1);
      if (i == 0) chk("strm_rvalid0", nt_rvalid, 0);
      else        chk("strm_rdata", nt_rdata, i - 1);
      nt_valid = 1'b1; nt_data = 8'(i);
      tick();
    end
    nt_valid = 1'b0;
    chk("strm_last", nt_rdata, 8'hFF);
    chk("strm_count", nt_cnt, 16'h0100);
    chk("strm_sum", nt_sum, 16'h7F80);
    tick();
    chk("strm_drained", nt_rvalid, 0);
    nt_rd_en = 1'b0;

    // Fill to full, pop once, drain
    do_reset();
    for (int i = 0; i < 13; i++) begin
      chk("fill_ready", nt_ready, vecs[i].exp_ready);
      chk("fill_rvalid", nt_rvalid, vecs[i].exp_rvalid);
      chk("fill_level", nt_level, vecs[i].exp_level);
      if (vecs[i].exp_rvalid) chk("fill_rdata", nt_rdata, vecs[i].exp_rdata);
      nt_valid = vecs[i].valid; nt_data = vecs[i].data; nt_rd_en = vecs[i].rd_en;
      tick();
    end
    nt_valid = 1'b0; nt_rd_en = 1'b0;
    chk("fill_count", nt_cnt, 5);
    chk("fill_sum", nt_sum, 16'h00FF);
    chk("fill_err", nt_err, 0);

    // Data changes while stalled
    do_reset();
    th_rd_en = 1'b1;
    lm = 8'hA5;
    seek_stall(lm, ok);
    chk("perr1_stall_found", ok, 1);
    th_valid = 1'b1; th_data = 8'h7E;
    tick(); lm = ref_lfsr(lm);
    chk("perr1_not_yet", th_err, 0);
    th_data = 8'h7F;
    tick(); lm = ref_lfsr(lm);
    chk("perr1_set", th_err, 1);
    th_valid = 1'b0;
    tick(); tick(); tick();
    chk("perr1_sticky", th_err, 1);

    // Valid withdrawn while stalled
    do_reset();
    chk("perr2_cleared", th_err, 0);
    th_rd_en = 1'b1;
    lm = 8'hA5;
    seek_stall(lm, ok);
    chk("perr2_stall_found", ok, 1);
    th_valid = 1'b1; th_data = 8'h7E;
    tick();
    th_valid = 1'b0;
    tick();
    chk("perr2_set", th_err, 1);

    // Asynchronous reset mid-stream with three bytes buffered
    do_reset();
    for (int i = 0; i < 10; i++) begin
      nt_valid = 1'b1; nt_data = 8'(i + 1);
      nt_rd_en = (i >= 1 && i <= 7);
      tick();
    end
    nt_valid = 1'b0; nt_rd_en = 1'b0;
    chk("mid_level", nt_level, 3);
    chk("mid_count", nt_cnt, 10);
    chk("mid_sum", nt_sum, 16'h0037);
    chk("mid_head", nt_rdata, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rvalid", nt_rvalid, 0);
    chk("async_level", nt_level, 0);
    chk("async_count", nt_cnt, 0);
    chk("async_sum", nt_sum, 0);
    tick();
    rst_n = 1'b1;
    nt_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_rvalid", nt_rvalid, 0);
    end
    nt_rd_en = 1'b0;
    nt_valid = 1'b1; nt_data = 8'hA0;
    tick();
    nt_valid = 1'b0;
    chk("post_rst_rdata", nt_rdata, 8'hA0);
    chk("post_rst_level", nt_level, 1);
    chk("post_rst_count", nt_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
